window3x3_gen: RTL and testbench

//  Builds the 3x3 neighbourhood for each pixel of a raster-order intensity stream.
//  It uses two line buffers and a 3-column shift window, and emits a packed 90-bit grid.

---
 rtl/window3x3_gen.sv | 128 ++++++++++++
 tb/tb_window3x3_gen.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// window3x3_gen
// Builds a 3x3 neighbourhood around each pixel of a raster-order intensity
// stream. Two line buffers supply the two previous lines at the current
// column, and a 3-column register window holds the last three columns.
// The packed grid output feeds the 3x3 convolution stages directly.
// Field k of oGrid is rowsel*3 + colsel, where rowsel 0 is the current line
// and colsel 0 is the newest column.

module window3x3_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DW     = 10
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [DW-1:0]   iPixel,
    input  logic            iValid,
    input  logic            iSOF,
    output logic [9*DW-1:0] oGrid,
    output logic            oValid,
    output logic [9:0]      oX,
    output logic [9:0]      oY
);

    localparam int CW = 10;
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_ROW = CW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic [CW-1:0] cur_col, cur_row;
    logic [AW-1:0] lb_addr;

    // Line buffers are never reset: rows 0 and 1 of each frame overwrite
    // every column before any window that uses them is marked valid.
    logic [DW-1:0] lb1_mem [WIDTH];
    logic [DW-1:0] lb2_mem [WIDTH];
    logic [DW-1:0] lb1_rd, lb2_rd;

    logic [8:0][DW-1:0] win_q, win_d;
    logic               valid_q, valid_d;
    logic [CW-1:0]      ox_q, ox_d;
    logic [CW-1:0]      oy_q, oy_d;

    // Position of the presented pixel; a start-of-frame forces it to (0,0).
    always_comb begin
        cur_col = iSOF ? '0 : col_q;
        cur_row = iSOF ? '0 : row_q;
        lb_addr = cur_col[AW-1:0];
        lb1_rd  = lb1_mem[lb_addr];
        lb2_rd  = lb2_mem[lb_addr];
    end

    // Advance raster counters on accepted pixels, wrapping line and frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iValid) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + CW'(1);
            end else begin
                col_d = cur_col + CW'(1);
                row_d = cur_row;
            end
        end
    end

    // Read-before-write line buffer update: LB1 ages into LB2.
    always_ff @(posedge clock) begin
        if (iValid) begin
            lb1_mem[lb_addr] <= iPixel;
            lb2_mem[lb_addr] <= lb1_rd;
        end
    end

    // Shift the window one column and load the new column at colsel 0.
    always_comb begin
        win_d = win_q;
        if (iValid) begin
            for (int rs = 0; rs < 3; rs++) begin
                win_d[3*rs+2] = win_q[3*rs+1];
                win_d[3*rs+1] = win_q[3*rs];
            end
            win_d[0] = iPixel;
            win_d[3] = lb1_rd;
            win_d[6] = lb2_rd;
        end
    end

    // A window is complete only when three rows and three columns of the
    // current frame have been seen; the centre sits one step up and left.
    always_comb begin
        valid_d = iValid && (cur_row >= CW'(2)) && (cur_col >= CW'(2));
        ox_d    = ox_q;
        oy_d    = oy_q;
        if (iValid) begin
            ox_d = cur_col - CW'(1);
            oy_d = cur_row - CW'(1);
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            valid_q <= 1'b0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            valid_q <= valid_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
        end
    end

    assign oGrid  = win_q;
    assign oValid = valid_q;
    assign oX     = ox_q;
    assign oY     = oy_q;

endmodule

// File: tb/tb_window3x3_gen.sv
// tb_window3x3_gen
// Directed bench for window3x3_gen with a 4x4 frame and p(r,c) = 16*r + c.

module tb_window3x3_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 10;

    logic            clock = 1'b0;
    logic            reset;
    logic [DW-1:0]   iPixel;
    logic            iValid;
    logic            iSOF;
    logic [9*DW-1:0] oGrid;
    logic            oValid;
    logic [9:0]      oX;
    logic [9:0]      oY;

    int n_checks = 0;
    int n_errors = 0;

    logic [9*DW-1:0] q_grid[$];
    int              q_x[$];
    int              q_y[$];
    int              q_idx[$];
    int              accepted = 0;
    logic            last_accept = 1'b0;
    int              idle_hits = 0;

    window3x3_gen #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
        .clock  (clock),
        .reset  (reset),
        .iPixel (iPixel),
        .iValid (iValid),
        .iSOF   (iSOF),
        .oGrid  (oGrid),
        .oValid (oValid),
        .oX     (oX),
        .oY     (oY)
    );

    always #5 clock = ~clock;

    // Track accepted pixels so each pulse can be tied to the pixel behind it.
    always @(posedge clock) begin
        last_accept <= iValid;
        if (iValid)
            accepted <= accepted + 1;
    end

    // Record every output pulse mid-cycle.
    always @(negedge clock) begin
        if (oValid === 1'b1) begin
            q_grid.push_back(oGrid);
            q_x.push_back(int'(oX));
            q_y.push_back(int'(oY));
            q_idx.push_back(accepted);
            if (!last_accept)
                idle_hits++;
        end
    end

    // Expected window whose newest pixel is (r,c), built from p(r,c)=16r+c.
    function automatic logic [9*DW-1:0] exp_grid(input int r, input int c);
        logic [9*DW-1:0] g;
        g = '0;
        for (int rs = 0; rs < 3; rs++)
            for (int cs = 0; cs < 3; cs++)
                g[DW*(3*rs+cs) +: DW] = DW'(16*(r-rs) + (c-cs));
        return g;
    endfunction

    task automatic send_value(input logic [DW-1:0] v, input logic sof, input int gap);
        iPixel = v;
        iValid = 1'b1;
        iSOF   = sof;
        @(posedge clock);
        #1;
        iValid = 1'b0;
        iSOF   = 1'b0;
        iPixel = '0;
        for (int i = 0; i < gap; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic send_frame(input logic sof_first, input int gap);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send_value(DW'(16*r + c), sof_first && (r == 0) && (c == 0), gap);
    endtask

    task automatic flush();
        for (int i = 0; i < 3; i++)
            @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        iValid = 1'b0;
        iSOF   = 1'b0;
        iPixel = '0;
        for (int i = 0; i < 3; i++)
            @(posedge clock);
        @(negedge clock);
        n_checks++;
        if (oValid !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_oValid: got %0b expected 0", oValid); end
        n_checks++;
        if (oGrid !== '0) begin n_errors++; $display("[TB] FAIL reset_oGrid: got %h expected 0", oGrid); end
        n_checks++;
        if (oX !== 10'd0 || oY !== 10'd0) begin n_errors++; $display("[TB] FAIL reset_oXY: got %0d,%0d expected 0,0", oX, oY); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if (oValid !== 1'b0 || oGrid !== '0 || oX !== 10'd0 || oY !== 10'd0) begin
            n_errors++;
            $display("[TB] FAIL post_release: got valid=%0b grid=%h x=%0d y=%0d expected all 0", oValid, oGrid, oX, oY);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_full_frame();
        int qs, base;
        qs   = q_x.size();
        base = accepted;
        send_frame(1'b1, 0);
        flush();
        n_checks++;
        if (q_x.size() - qs != 4) begin n_errors++; $display("[TB] FAIL full_count: got %0d expected 4", q_x.size() - qs); end
        if (q_x.size() > qs) begin
            n_checks++;
            if (q_grid[qs][9:0] !== 10'd34 || q_grid[qs][39:30] !== 10'd18 || q_grid[qs][69:60] !== 10'd2 ||
                q_grid[qs][89:80] !== 10'd0 || q_grid[qs][29:20] !== 10'd32) begin
                n_errors++;
                $display("[TB] FAIL full_first_fields: got %h expected fields 34,18,2,0,32", q_grid[qs]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            int r, c;
            r = 2 + k / 2;
            c = 2 + k % 2;
            if (qs + k < q_x.size()) begin
                n_checks++;
                if (q_grid[qs+k] !== exp_grid(r, c)) begin n_errors++; $display("[TB] FAIL full_grid%0d: got %h expected %h", k, q_grid[qs+k], exp_grid(r, c)); end
                n_checks++;
                if (q_x[qs+k] != c - 1 || q_y[qs+k] != r - 1) begin n_errors++; $display("[TB] FAIL full_xy%0d: got %0d,%0d expected %0d,%0d", k, q_x[qs+k], q_y[qs+k], c - 1, r - 1); end
                n_checks++;
                if (q_idx[qs+k] - base != 4*r + c + 1) begin n_errors++; $display("[TB] FAIL full_latency%0d: got %0d expected %0d", k, q_idx[qs+k] - base, 4*r + c + 1); end
            end
        end
    endtask

    task automatic test_sparse();
        int qs, idle0;
        qs    = q_x.size();
        idle0 = idle_hits;
        send_frame(1'b1, 2);
        flush();
        n_checks++;
        if (q_x.size() - qs != 4) begin n_errors++; $display("[TB] FAIL sparse_count: got %0d expected 4", q_x.size() - qs); end
        n_checks++;
        if (idle_hits != idle0) begin n_errors++; $display("[TB] FAIL sparse_idle: got %0d idle pulses expected 0", idle_hits - idle0); end
        for (int k = 0; k < 4; k++) begin
            int r, c;
            r = 2 + k / 2;
            c = 2 + k % 2;
            if (qs + k < q_x.size()) begin
                n_checks++;
                if (q_grid[qs+k] !== exp_grid(r, c) || q_x[qs+k] != c - 1 || q_y[qs+k] != r - 1) begin
                    n_errors++;
                    $display("[TB] FAIL sparse_win%0d: got %h (%0d,%0d) expected %h (%0d,%0d)", k, q_grid[qs+k], q_x[qs+k], q_y[qs+k], exp_grid(r, c), c - 1, r - 1);
                end
            end
        end
    endtask

    task automatic test_mid_sof();
        int qs, base;
        qs   = q_x.size();
        base = accepted;
        for (int i = 0; i < 7; i++)
            send_value(DW'(1000 - i), (i == 0), 0);
        send_frame(1'b1, 0);
        flush();
        n_checks++;
        if (q_x.size() - qs != 4) begin n_errors++; $display("[TB] FAIL midsof_count: got %0d expected 4", q_x.size() - qs); end
        if (q_x.size() > qs) begin
            n_checks++;
            if (q_x[qs] != 1 || q_y[qs] != 1 || q_idx[qs] - base != 7 + 11) begin
                n_errors++;
                $display("[TB] FAIL midsof_first: got x=%0d y=%0d idx=%0d expected 1,1,18", q_x[qs], q_y[qs], q_idx[qs] - base);
            end
        end
        for (int k = 0; k < 4; k++) begin
            int r, c;
            r = 2 + k / 2;
            c = 2 + k % 2;
            if (qs + k < q_x.size()) begin
                n_checks++;
                if (q_grid[qs+k] !== exp_grid(r, c)) begin n_errors++; $display("[TB] FAIL midsof_grid%0d: got %h expected %h", k, q_grid[qs+k], exp_grid(r, c)); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int qs, base;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < W; c++)
                send_value(DW'(16*r + c), (r == 0) && (c == 0), 0);
        n_checks++;
        if (oValid !== 1'b1) begin n_errors++; $display("[TB] FAIL rstmid_pre: got %0b expected 1", oValid); end
        reset = 1'b1;
        #1;
        n_checks++;
        if (oValid !== 1'b0 || oGrid !== '0) begin n_errors++; $display("[TB] FAIL rstmid_drop: got valid=%0b grid=%h expected 0,0", oValid, oGrid); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        qs   = q_x.size();
        base = accepted;
        send_frame(1'b0, 0);
        flush();
        n_checks++;
        if (q_x.size() - qs != 4) begin n_errors++; $display("[TB] FAIL rstmid_count: got %0d expected 4", q_x.size() - qs); end
        for (int k = 0; k < 4; k++) begin
            int r, c;
            r = 2 + k / 2;
            c = 2 + k % 2;
            if (qs + k < q_x.size()) begin
                n_checks++;
                if (q_grid[qs+k] !== exp_grid(r, c) || q_x[qs+k] != c - 1 || q_y[qs+k] != r - 1 || q_idx[qs+k] - base != 4*r + c + 1) begin
                    n_errors++;
                    $display("[TB] FAIL rstmid_win%0d: got %h (%0d,%0d) idx %0d expected %h (%0d,%0d) idx %0d", k, q_grid[qs+k], q_x[qs+k], q_y[qs+k], q_idx[qs+k] - base, exp_grid(r, c), c - 1, r - 1, 4*r + c + 1);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int qs, base;
        qs   = q_x.size();
        base = accepted;
        send_frame(1'b1, 0);
        send_frame(1'b0, 0);
        flush();
        n_checks++;
        if (q_x.size() - qs != 8) begin n_errors++; $display("[TB] FAIL b2b_count: got %0d expected 8", q_x.size() - qs); end
        for (int k = 0; k < 8; k++) begin
            int f, r, c;
            f = k / 4;
            r = 2 + (k % 4) / 2;
            c = 2 + k % 2;
            if (qs + k < q_x.size()) begin
                n_checks++;
                if (q_grid[qs+k] !== exp_grid(r, c) || q_x[qs+k] != c - 1 || q_y[qs+k] != r - 1 || q_idx[qs+k] - base != 16*f + 4*r + c + 1) begin
                    n_errors++;
                    $display("[TB] FAIL b2b_win%0d: got %h (%0d,%0d) idx %0d expected %h (%0d,%0d) idx %0d", k, q_grid[qs+k], q_x[qs+k], q_y[qs+k], q_idx[qs+k] - base, exp_grid(r, c), c - 1, r - 1, 16*f + 4*r + c + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_sparse();
        test_mid_sof();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
